// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared opcodes, sequencer states and opcode check
package vector_pkg;

    localparam logic [7:0] OP_RELU    = 8'h05;
    localparam logic [7:0] OP_ADD     = 8'h06;
    localparam logic [7:0] OP_SOFTMAX = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic is_supported_op(input logic [7:0] op);
        return (op == OP_RELU) || (op == OP_ADD) || (op == OP_SOFTMAX);
    endfunction

endpackage

// File: rtl/vector_alu_sequencer.sv
// rtl/vector_alu_sequencer.sv - vector command issue stage feeding the ALU
module vector_alu_sequencer
    import vector_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [7:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_t        state;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic              err_q;

    // Stage 1 = SRAM data returning, stage 2 = registered ALU result returning.
    logic              v1;
    logic              v2;
    logic [LEN_W-1:0]  idx1;
    logic [LEN_W-1:0]  idx2;

    logic              accept;
    logic              last_elem;

    // Ready is held low while reset is asserted so nothing looks acceptable then.
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign last_elem = (cnt == (len_q - LEN_W'(1)));

    // Command latch, element counter and IDLE/ISSUE/DRAIN/DONE sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_opcode;
                        src1_q <= cmd_src1;
                        src2_q <= cmd_src2;
                        dst_q  <= cmd_dst;
                        len_q  <= cmd_len;
                        cnt    <= '0;
                        if (is_supported_op(cmd_opcode) && (cmd_len != '0)) begin
                            state <= ST_ISSUE;
                            err_q <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            err_q <= !is_supported_op(cmd_opcode);
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + LEN_W'(1);
                    if (last_elem) begin
                        state <= ST_DRAIN;
                    end
                end
                // Leave once stage 1 is empty: stage 2 retires the final write this
                // cycle, so both valids are clear when DONE is entered.
                ST_DRAIN: begin
                    if (!v1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid/index pipeline tracking the read-to-result latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            idx1 <= '0;
            idx2 <= '0;
        end else begin
            v1   <= rd_en;
            idx1 <= cnt;
            v2   <= v1;
            idx2 <= idx1;
        end
    end

    assign rd_en      = (state == ST_ISSUE);
    assign rd_addr1   = rd_en ? (src1_q + ADDR_W'(cnt)) : '0;
    assign rd_addr2   = rd_en ? (src2_q + ADDR_W'(cnt)) : '0;

    assign alu_opcode = op_q;
    assign alu_in1    = v1 ? rd_data1 : '0;
    assign alu_in2    = v1 ? rd_data2 : '0;

    assign wr_en      = v2;
    assign wr_addr    = v2 ? (dst_q + ADDR_W'(idx2)) : '0;
    assign wr_data    = v2 ? alu_out : '0;

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign err        = done && err_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb/tb_vector_alu_sequencer.sv - self-checking bench for vector_alu_sequencer
module tb_vector_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [7:0]  cmd_src1 = '0;
    logic [7:0]  cmd_src2 = '0;
    logic [7:0]  cmd_dst = '0;
    logic [7:0]  cmd_len = '0;
    logic        rd_en;
    logic [7:0]  rd_addr1;
    logic [7:0]  rd_addr2;
    logic [31:0] rd_data1 = '0;
    logic [31:0] rd_data2 = '0;
    logic [7:0]  alu_opcode;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] d;
        logic [7:0] len;
        logic       exp_err;
        int         exp_n;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  sbq[$];
    vec_t tbl[7];

    vector_alu_sequencer #(.DATA_W(32), .ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'h05:   return a[31] ? 32'h0 : a;
            8'h06:   return a + b;
            8'h07:   return a;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous buffer with 1-cycle read latency, plus a registered ALU.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem[rd_addr1];
            rd_data2 <= mem[rd_addr2];
        end
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ld_en) mem[ld_addr] <= ld_data;
        alu_out <= alu_f(alu_opcode, alu_in1, alu_in2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        logic [7:0] a1, a2, ad;
        wr_t e;
        for (int i = 0; i < v.exp_n; i++) begin
            a1 = v.s1 + 8'(i);
            a2 = v.s2 + 8'(i);
            ad = v.d + 8'(i);
            e.a = ad;
            e.d = alu_f(v.op, mem[a1], mem[a2]);
            sbq.push_back(e);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_opcode = v.op;
        cmd_src1 = v.s1;
        cmd_src2 = v.s2;
        cmd_dst = v.d;
        cmd_len = v.len;
        cmd_valid = 1'b1;
    endtask

    // Called at the negedge of cycle 1; follows the command to the cycle after done.
    task automatic watch(input vec_t v);
        int done_cyc = -1;
        int first_wr = -1;
        int last_wr = -1;
        int rd_cnt = 0;
        int wr_cnt = 0;
        logic err_seen = 1'b0;
        logic [7:0] ea;
        wr_t e;
        for (int c = 1; c <= int'(v.len) + 10; c++) begin
            if (c == 1) chk("alu_opcode", {24'h0, alu_opcode}, {24'h0, v.op});
            if (rd_en) begin
                ea = v.s1 + 8'(rd_cnt);
                chk("rd_addr1", {24'h0, rd_addr1}, {24'h0, ea});
                ea = v.s2 + 8'(rd_cnt);
                chk("rd_addr2", {24'h0, rd_addr2}, {24'h0, ea});
                rd_cnt++;
            end
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h cycle=%0d", wr_addr, wr_data, c);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", {24'h0, wr_addr}, {24'h0, e.a});
                    chk("wr_data", wr_data, e.d);
                end
                wr_cnt++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
            end
            if (done_cyc >= 0) begin
                chk("ready_after_done", {31'h0, cmd_ready}, 32'h1);
                chk("done_one_cycle", {31'h0, done}, 32'h0);
                break;
            end
            if (done) begin
                done_cyc = c;
                err_seen = err;
            end
            @(negedge clk);
        end
        chk("done_cycle", done_cyc, v.exp_done);
        chk("err", {31'h0, err_seen}, {31'h0, v.exp_err});
        chk("rd_count", rd_cnt, v.exp_n);
        chk("wr_count", wr_cnt, v.exp_n);
        if (v.exp_n > 0) begin
            chk("first_wr_cycle", first_wr, 3);
            chk("last_wr_cycle", last_wr, int'(v.len) + 2);
        end
        chk("scoreboard_empty", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_cmd(input vec_t v);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
        push_exp(v);
        drive_cmd(v);
        @(negedge clk);
        cmd_valid = 1'b0;
        watch(v);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        //              op     s1     s2     d      len  err   n  done
        tbl[0] = '{8'h06, 8'h10, 8'h20, 8'h30, 8'd4, 1'b0, 4, 7};
        tbl[1] = '{8'h05, 8'h40, 8'h50, 8'h60, 8'd3, 1'b0, 3, 6};
        tbl[2] = '{8'h06, 8'h70, 8'h71, 8'h72, 8'd0, 1'b0, 0, 1};
        tbl[3] = '{8'h09, 8'h10, 8'h20, 8'h90, 8'd4, 1'b1, 0, 1};
        tbl[4] = '{8'h06, 8'hFE, 8'h80, 8'hFF, 8'd4, 1'b0, 4, 7};
        tbl[5] = '{8'h07, 8'h88, 8'h8C, 8'hD0, 8'd2, 1'b0, 2, 5};
        tbl[6] = '{8'h05, 8'h44, 8'h45, 8'hE0, 8'd1, 1'b0, 1, 4};

        for (int i = 0; i < 256; i++) ld(8'(i), $urandom);
        for (int i = 0; i < 4; i++) begin
            ld(8'h10 + 8'(i), 32'(i + 1));
            ld(8'h20 + 8'(i), 32'((i + 1) * 10));
        end
        ld(8'h40, 32'hFFFF_FFFF);
        ld(8'h41, 32'd5);
        ld(8'h42, 32'h8000_0000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rd_en", {31'h0, rd_en}, 32'h0);
        chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
        chk("rst_alu_opcode", {24'h0, alu_opcode}, 32'h0);
        chk("rst_alu_in1", alu_in1, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

        for (int i = 0; i < 4; i++) chk("add_result", mem[8'h30 + 8'(i)], 32'((i + 1) * 11));
        chk("relu_neg1", mem[8'h60], 32'h0);
        chk("relu_pos", mem[8'h61], 32'd5);
        chk("relu_min", mem[8'h62], 32'h0);

        // Reset in cycle 4 of a len=8 command, with cmd_valid held throughout.
        rv = '{8'h06, 8'hA0, 8'hB0, 8'hC0, 8'd8, 1'b0, 8, 11};
        chk("ready_before_rst_cmd", {31'h0, cmd_ready}, 32'h1);
        drive_cmd(rv);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        chk("busy_before_rst", {31'h0, busy}, 32'h1);
        chk("wr_en_before_rst", {31'h0, wr_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_en", {31'h0, wr_en}, 32'h0);
        chk("rst_mid_rd_en", {31'h0, rd_en}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold_done", {31'h0, done}, 32'h0);
            chk("rst_hold_wr_en", {31'h0, wr_en}, 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'h0, cmd_ready}, 32'h1);
        push_exp(rv);
        @(negedge clk);
        cmd_valid = 1'b0;
        watch(rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
